// File: rtl/dest_drain_ctrl_if.sv
// Bundles everything between the drain controller and its neighbours:
// the D0/D1 FIFO read side, the D0/D1 sink channels, the counter readout
// and the control/status lines. clk and reset_L stay outside as plain ports.
//   master : the environment (FIFOs, sinks, system controller)
//   slave  : dest_drain_ctrl
interface dest_drain_ctrl_if #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 5
);
    // control / status
    logic                  init;
    logic                  active_out;
    logic                  idle_out;
    // FIFO read side
    logic                  empty_fifo_D0;
    logic                  empty_fifo_D1;
    logic [DATA_WIDTH-1:0] data_out_D0;
    logic [DATA_WIDTH-1:0] data_out_D1;
    logic                  D0_pop;
    logic                  D1_pop;
    // sink side
    logic                  ready_D0;
    logic                  ready_D1;
    logic [DATA_WIDTH-1:0] data_D0;
    logic                  valid_D0;
    logic [DATA_WIDTH-1:0] data_D1;
    logic                  valid_D1;
    // counter readout
    logic                  req;
    logic                  idx;
    logic [CNT_WIDTH-1:0]  contador;
    logic                  valid_contador;

    modport master (
        output init, empty_fifo_D0, empty_fifo_D1, data_out_D0, data_out_D1,
               ready_D0, ready_D1, req, idx,
        input  D0_pop, D1_pop, data_D0, valid_D0, data_D1, valid_D1,
               contador, valid_contador, active_out, idle_out
    );

    modport slave (
        input  init, empty_fifo_D0, empty_fifo_D1, data_out_D0, data_out_D1,
               ready_D0, ready_D1, req, idx,
        output D0_pop, D1_pop, data_D0, valid_D0, data_D1, valid_D1,
               contador, valid_contador, active_out, idle_out
    );
endinterface

// File: rtl/dest_drain_ctrl.sv
// dest_drain_ctrl: drains the D0/D1 destination FIFOs into their sinks.
// Pops are issued combinationally while ACTIVE whenever a FIFO is non-empty
// and its sink is ready; the FIFO returns the word one cycle later and it is
// registered onto data_Dx with a one-cycle valid_Dx pulse (pop -> valid = 2
// cycles). Delivered words are counted per destination (wrapping) and the
// counts can be read out via req/idx while IDLE.
// Ports:
//   clk     : system clock, rising edge
//   reset_L : asynchronous active-low reset
//   bus     : dest_drain_ctrl_if.slave (FIFO, sink, readout, status lines)
module dest_drain_ctrl #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 5
) (
    input  logic             clk,
    input  logic             reset_L,
    dest_drain_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic                  pop_d0_s;
    logic                  pop_d1_s;
    logic                  clear_cnt_s;
    logic                  pop_q_d0_r;
    logic                  pop_q_d1_r;
    logic [DATA_WIDTH-1:0] data_d0_r;
    logic [DATA_WIDTH-1:0] data_d1_r;
    logic                  valid_d0_r;
    logic                  valid_d1_r;
    logic [CNT_WIDTH-1:0]  cnt_d0_r;
    logic [CNT_WIDTH-1:0]  cnt_d1_r;
    logic [CNT_WIDTH-1:0]  contador_r;
    logic                  valid_contador_r;
    logic                  active_r;
    logic                  idle_r;

    // State register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r <= ST_RESET;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; init overrides every other condition
    always_comb begin
        next_state_s = state_r;
        if (bus.init) begin
            next_state_s = ST_INIT;
        end else begin
            case (state_r)
                ST_RESET:  next_state_s = ST_IDLE;
                ST_INIT:   next_state_s = ST_IDLE;
                ST_IDLE: begin
                    if (!bus.empty_fifo_D0 || !bus.empty_fifo_D1) begin
                        next_state_s = ST_ACTIVE;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                // Stay until the last popped word has left pop_q, so its
                // count is already updated by the time readout is allowed.
                ST_ACTIVE: begin
                    if (bus.empty_fifo_D0 && bus.empty_fifo_D1 &&
                        !pop_q_d0_r && !pop_q_d1_r) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_ACTIVE;
                    end
                end
                default:   next_state_s = ST_RESET;
            endcase
        end
    end

    // Pop strobes, combinational on the current empty flags and readiness
    always_comb begin
        pop_d0_s    = (state_r == ST_ACTIVE) && !bus.empty_fifo_D0 && bus.ready_D0;
        pop_d1_s    = (state_r == ST_ACTIVE) && !bus.empty_fifo_D1 && bus.ready_D1;
        clear_cnt_s = bus.init || (state_r == ST_INIT);
    end

    // Two-stage delivery pipe: pop -> pop_q -> registered word with valid
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pop_q_d0_r <= 1'b0;
            pop_q_d1_r <= 1'b0;
            valid_d0_r <= 1'b0;
            valid_d1_r <= 1'b0;
            data_d0_r  <= {DATA_WIDTH{1'b0}};
            data_d1_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            pop_q_d0_r <= pop_d0_s;
            pop_q_d1_r <= pop_d1_s;
            valid_d0_r <= pop_q_d0_r;
            valid_d1_r <= pop_q_d1_r;
            if (pop_q_d0_r) begin
                data_d0_r <= bus.data_out_D0;
            end
            if (pop_q_d1_r) begin
                data_d1_r <= bus.data_out_D1;
            end
        end
    end

    // Delivered-word counters; wrap naturally, held clear during init
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_d0_r <= {CNT_WIDTH{1'b0}};
            cnt_d1_r <= {CNT_WIDTH{1'b0}};
        end else if (clear_cnt_s) begin
            cnt_d0_r <= {CNT_WIDTH{1'b0}};
            cnt_d1_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (valid_d0_r) begin
                cnt_d0_r <= cnt_d0_r + CNT_WIDTH'(1);
            end
            if (valid_d1_r) begin
                cnt_d1_r <= cnt_d1_r + CNT_WIDTH'(1);
            end
        end
    end

    // Counter readout, honoured only in IDLE; contador holds otherwise
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            contador_r       <= {CNT_WIDTH{1'b0}};
            valid_contador_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && bus.req) begin
            contador_r       <= bus.idx ? cnt_d1_r : cnt_d0_r;
            valid_contador_r <= 1'b1;
        end else begin
            valid_contador_r <= 1'b0;
        end
    end

    // Status flags registered from the next state so they track state_r
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            active_r <= 1'b0;
            idle_r   <= 1'b0;
        end else begin
            active_r <= (next_state_s == ST_ACTIVE);
            idle_r   <= (next_state_s == ST_IDLE);
        end
    end

    assign bus.D0_pop         = pop_d0_s;
    assign bus.D1_pop         = pop_d1_s;
    assign bus.data_D0        = data_d0_r;
    assign bus.valid_D0       = valid_d0_r;
    assign bus.data_D1        = data_d1_r;
    assign bus.valid_D1       = valid_d1_r;
    assign bus.contador       = contador_r;
    assign bus.valid_contador = valid_contador_r;
    assign bus.active_out     = active_r;
    assign bus.idle_out       = idle_r;

endmodule

// File: tb/tb_dest_drain_ctrl.sv
// Directed bench for dest_drain_ctrl: FIFO models feed the DUT, a monitor
// records delivered words, and each test task checks its own expectations.
module tb_dest_drain_ctrl;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    dest_drain_ctrl_if #(.DATA_WIDTH(6), .CNT_WIDTH(5)) bus ();

    dest_drain_ctrl #(.DATA_WIDTH(6), .CNT_WIDTH(5)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // FIFO models: tasks write at negedge, reads advance at posedge on pop
    logic [5:0] mem0 [256];
    logic [5:0] mem1 [256];
    logic [7:0] wr0 = 8'd0;
    logic [7:0] wr1 = 8'd0;
    logic [7:0] rd0;
    logic [7:0] rd1;

    assign bus.empty_fifo_D0 = (rd0 == wr0);
    assign bus.empty_fifo_D1 = (rd1 == wr1);

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rd0 <= 8'd0;
            rd1 <= 8'd0;
            bus.data_out_D0 <= 6'd0;
            bus.data_out_D1 <= 6'd0;
        end else begin
            if (bus.D0_pop) begin
                bus.data_out_D0 <= mem0[rd0];
                rd0 <= rd0 + 8'd1;
            end
            if (bus.D1_pop) begin
                bus.data_out_D1 <= mem1[rd1];
                rd1 <= rd1 + 8'd1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every delivered word and the cycle it appeared in
    logic [5:0] got0[$];
    logic [5:0] got1[$];
    int         got0_t[$];
    int         got1_t[$];

    always @(negedge clk) begin
        if (bus.valid_D0 === 1'b1) begin
            got0.push_back(bus.data_D0);
            got0_t.push_back(cyc);
        end
        if (bus.valid_D1 === 1'b1) begin
            got1.push_back(bus.data_D1);
            got1_t.push_back(cyc);
        end
    end

    task automatic push0(input logic [5:0] v);
        mem0[wr0] = v;
        wr0 = wr0 + 8'd1;
    endtask

    task automatic push1(input logic [5:0] v);
        mem1[wr1] = v;
        wr1 = wr1 + 8'd1;
    endtask

    task automatic do_init();
        bus.init = 1'b1;
        repeat (2) @(negedge clk);
        bus.init = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.idle_out) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic read_cnt(input logic i, output logic [4:0] val, output logic vld);
        bus.req = 1'b1;
        bus.idx = i;
        @(negedge clk);
        val = bus.contador;
        vld = bus.valid_contador;
        bus.req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.D0_pop, bus.D1_pop, bus.valid_D0, bus.valid_D1, bus.valid_contador} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 00000",
                     {bus.D0_pop, bus.D1_pop, bus.valid_D0, bus.valid_D1, bus.valid_contador});
        end
        checks++;
        if ({bus.data_D0, bus.data_D1, bus.contador} !== 17'd0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {bus.data_D0, bus.data_D1, bus.contador});
        end
        checks++;
        if ({bus.active_out, bus.idle_out} !== 2'b00) begin
            errors++;
            $display("FAIL reset_status got %b exp 00", {bus.active_out, bus.idle_out});
        end
        reset_L = 1'b1;
        bus.init = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.active_out, bus.idle_out} !== 2'b00) begin
                errors++;
                $display("FAIL init_status cycle %0d got %b exp 00", i, {bus.active_out, bus.idle_out});
            end
        end
        bus.init = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.active_out, bus.idle_out} !== 2'b01) begin
            errors++;
            $display("FAIL post_init_idle got %b exp 01", {bus.active_out, bus.idle_out});
        end
    endtask

    task automatic test_single();
        logic [4:0] v;
        logic       vl;
        do_init();
        push0(6'h2A);
        @(negedge clk);
        checks++;
        if ({bus.active_out, bus.D0_pop, bus.D1_pop} !== 3'b110) begin
            errors++;
            $display("FAIL single_pop got %b exp 110", {bus.active_out, bus.D0_pop, bus.D1_pop});
        end
        @(negedge clk);
        checks++;
        if ({bus.D0_pop, bus.valid_D0} !== 2'b00) begin
            errors++;
            $display("FAIL single_gap got %b exp 00", {bus.D0_pop, bus.valid_D0});
        end
        @(negedge clk);
        checks++;
        if ({bus.valid_D0, bus.data_D0} !== {1'b1, 6'h2A}) begin
            errors++;
            $display("FAIL single_valid got %b/%h exp 1/2a", bus.valid_D0, bus.data_D0);
        end
        @(negedge clk);
        checks++;
        if ({bus.idle_out, bus.valid_D0, bus.data_D0} !== {2'b10, 6'h2A}) begin
            errors++;
            $display("FAIL single_return got %b/%b/%h exp 1/0/2a", bus.idle_out, bus.valid_D0, bus.data_D0);
        end
        read_cnt(1'b0, v, vl);
        checks++;
        if ({vl, v} !== {1'b1, 5'd1}) begin
            errors++;
            $display("FAIL single_cnt_d0 got %b/%0d exp 1/1", vl, v);
        end
        read_cnt(1'b1, v, vl);
        checks++;
        if ({vl, v} !== {1'b1, 5'd0}) begin
            errors++;
            $display("FAIL single_cnt_d1 got %b/%0d exp 1/0", vl, v);
        end
    endtask

    task automatic test_concurrent();
        logic [5:0] e0 [4];
        logic [5:0] e1 [3];
        logic [4:0] v;
        logic       vl;
        bit         ok;
        e0 = '{6'h11, 6'h12, 6'h13, 6'h14};
        e1 = '{6'h21, 6'h22, 6'h23};
        do_init();
        got0.delete(); got0_t.delete(); got1.delete(); got1_t.delete();
        for (int i = 0; i < 4; i++) push0(e0[i]);
        for (int i = 0; i < 3; i++) push1(e1[i]);
        wait_idle(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL conc_timeout got busy exp idle");
        end
        checks++;
        if (got0.size() != 4 || got1.size() != 3) begin
            errors++;
            $display("FAIL conc_count got %0d/%0d exp 4/3", got0.size(), got1.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got0[i] !== e0[i] || got0_t[i] != got0_t[0] + i) begin
                    errors++;
                    $display("FAIL conc_d0[%0d] got %h@%0d exp %h@%0d", i, got0[i], got0_t[i], e0[i], got0_t[0] + i);
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got1[i] !== e1[i] || got1_t[i] != got1_t[0] + i) begin
                    errors++;
                    $display("FAIL conc_d1[%0d] got %h@%0d exp %h@%0d", i, got1[i], got1_t[i], e1[i], got1_t[0] + i);
                end
            end
        end
        read_cnt(1'b0, v, vl);
        checks++;
        if ({vl, v} !== {1'b1, 5'd4}) begin
            errors++;
            $display("FAIL conc_cnt_d0 got %b/%0d exp 1/4", vl, v);
        end
        read_cnt(1'b1, v, vl);
        checks++;
        if ({vl, v} !== {1'b1, 5'd3}) begin
            errors++;
            $display("FAIL conc_cnt_d1 got %b/%0d exp 1/3", vl, v);
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] e1 [5];
        logic [4:0] v;
        logic       vl;
        bit         ok;
        int         late_valids;
        int         late_pops;
        e1 = '{6'h31, 6'h32, 6'h33, 6'h34, 6'h35};
        do_init();
        got1.delete(); got1_t.delete();
        for (int i = 0; i < 5; i++) push1(e1[i]);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.D1_pop !== 1'b1) begin
                errors++;
                $display("FAIL bp_pop%0d got %b exp 1", i, bus.D1_pop);
            end
        end
        @(negedge clk);
        bus.ready_D1 = 1'b0;
        late_valids = 0;
        late_pops = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.valid_D1 === 1'b1) late_valids++;
            if (bus.D1_pop !== 1'b0) late_pops++;
        end
        checks++;
        if (late_valids > 2 || late_pops != 0 || bus.active_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall got valids=%0d pops=%0d active=%b exp <=2/0/1", late_valids, late_pops, bus.active_out);
        end
        bus.ready_D1 = 1'b1;
        wait_idle(40, ok);
        checks++;
        if (!ok || got1.size() != 5) begin
            errors++;
            $display("FAIL bp_total got ok=%0d n=%0d exp 1/5", ok, got1.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got1[i] !== e1[i]) begin
                    errors++;
                    $display("FAIL bp_d1[%0d] got %h exp %h", i, got1[i], e1[i]);
                end
            end
        end
        read_cnt(1'b1, v, vl);
        checks++;
        if ({vl, v} !== {1'b1, 5'd5}) begin
            errors++;
            $display("FAIL bp_cnt_d1 got %b/%0d exp 1/5", vl, v);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] v;
        logic       vl;
        bit         ok;
        do_init();
        got0.delete(); got0_t.delete();
        for (int i = 0; i < 33; i++) push0(6'(i + 1));
        wait_idle(120, ok);
        checks++;
        if (!ok || got0.size() != 33) begin
            errors++;
            $display("FAIL wrap_total got ok=%0d n=%0d exp 1/33", ok, got0.size());
        end
        read_cnt(1'b0, v, vl);
        checks++;
        if ({vl, v} !== {1'b1, 5'd1}) begin
            errors++;
            $display("FAIL wrap_cnt_d0 got %b/%0d exp 1/1", vl, v);
        end
    endtask

    task automatic test_gating_init();
        logic [5:0] e0 [3];
        logic [4:0] v;
        logic       vl;
        bit         ok;
        e0 = '{6'h05, 6'h0A, 6'h0F};
        do_init();
        got0.delete(); got0_t.delete();
        for (int i = 0; i < 3; i++) push0(e0[i]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.active_out, bus.D0_pop, bus.valid_contador} !== 3'b110) begin
                errors++;
                $display("FAIL gate_active%0d got %b exp 110", i, {bus.active_out, bus.D0_pop, bus.valid_contador});
            end
            bus.req = 1'b1;
            bus.idx = 1'b0;
        end
        bus.init = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.D0_pop, bus.valid_contador, bus.active_out} !== 3'b000) begin
                errors++;
                $display("FAIL gate_init%0d got %b exp 000", i, {bus.D0_pop, bus.valid_contador, bus.active_out});
            end
        end
        bus.init = 1'b0;
        bus.req = 1'b0;
        wait_idle(10, ok);
        checks++;
        if (!ok || got0.size() != 3) begin
            errors++;
            $display("FAIL gate_inflight got ok=%0d n=%0d exp 1/3", ok, got0.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got0[i] !== e0[i]) begin
                    errors++;
                    $display("FAIL gate_d0[%0d] got %h exp %h", i, got0[i], e0[i]);
                end
            end
        end
        read_cnt(1'b0, v, vl);
        checks++;
        if ({vl, v} !== {1'b1, 5'd0}) begin
            errors++;
            $display("FAIL gate_cnt_d0 got %b/%0d exp 1/0", vl, v);
        end
        read_cnt(1'b1, v, vl);
        checks++;
        if ({vl, v} !== {1'b1, 5'd0}) begin
            errors++;
            $display("FAIL gate_cnt_d1 got %b/%0d exp 1/0", vl, v);
        end
    endtask

    initial begin
        bus.init = 1'b0;
        bus.ready_D0 = 1'b1;
        bus.ready_D1 = 1'b1;
        bus.req = 1'b0;
        bus.idx = 1'b0;
        test_reset();
        test_single();
        test_concurrent();
        test_backpressure();
        test_wrap();
        test_gating_init();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
